// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

    localparam int unsigned DEFAULT_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        TEST  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/seq_divider_datapath.sv
// Remainder/quotient/divisor registers and the W+1-bit compare-subtract for the divider.
module seq_divider_datapath #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         zero_load,
    input  logic         shift,
    input  logic         test,
    input  logic         take,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         ge,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    // rem carries one guard bit so the post-shift value never loses its MSB
    logic [W:0]   rem;
    logic [W-1:0] q;
    logic [W-1:0] d;
    logic [W:0]   diff_c;

    assign diff_c    = rem - {1'b0, d};
    assign ge        = (rem >= {1'b0, d});
    assign quotient  = q;
    assign remainder = rem[W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem <= '0;
            q   <= '0;
            d   <= '0;
        end else if (load) begin
            d <= divisor;
            if (zero_load) begin
                rem <= {1'b0, dividend};
                q   <= '1;
            end else begin
                rem <= '0;
                q   <= dividend;
            end
        end else if (shift) begin
            rem <= {rem[W-1:0], q[W-1]};
            q   <= {q[W-2:0], 1'b0};
        end else if (test && take) begin
            rem  <= diff_c;
            q[0] <= 1'b1;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring shift-subtract divider: FSM controller around seq_divider_datapath.
// Optional feature macro: SEQ_DIVIDER_ZERO_DETECT_EN (early finish with dbz on divisor 0).
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         dbz
);

    localparam int unsigned CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             load_c;
    logic             shift_c;
    logic             test_c;
    logic             ge_c;
    logic             zero_div_c;
    logic             zero_load_c;

`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
    assign zero_div_c = (divisor == '0);
`else
    assign zero_div_c = 1'b0;
`endif

    assign load_c      = (state == LOAD);
    assign shift_c     = (state == SHIFT);
    assign test_c      = (state == TEST);
    assign zero_load_c = load_c & zero_div_c;

    seq_divider_datapath #(.W(W)) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .load      (load_c),
        .zero_load (zero_load_c),
        .shift     (shift_c),
        .test      (test_c),
        .take      (ge_c),
        .dividend  (dividend),
        .divisor   (divisor),
        .ge        (ge_c),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // Controller; busy/done/dbz are registered alongside the state transitions
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dbz   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    count <= '0;
                    dbz   <= zero_div_c;
                    if (zero_div_c) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    state <= TEST;
                end
                TEST: begin
                    count <= count + CNT_W'(1);
                    if (count == LAST_CNT) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= SHIFT;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider at W=4.
module tb_seq_divider;
    import seq_divider_pkg::*;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         dbz;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SEQ_DIVIDER_ZERO_DETECT_EN
    localparam int ZERO_EDGES = 2;
    localparam logic ZERO_DBZ = 1'b1;
`else
    localparam int ZERO_EDGES = 10;
    localparam logic ZERO_DBZ = 1'b0;
`endif

    // Start one operation; edge 1 is the edge that samples start. Returns one edge after done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic z, output int edges);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        edges = 1;
        start = 1'b0;
        while (done !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        q = quotient;
        r = remainder;
        z = dbz;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if ({quotient, remainder, busy, done, dbz} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got q=%0d r=%0d busy=%0b done=%0b dbz=%0b expected all 0",
                     quotient, remainder, busy, done, dbz);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [W-1:0] q, r; logic z; int e;
        run_op(4'd13, 4'd3, q, r, z, e);
        n_checks++;
        if (e !== 10) begin n_fail++; $display("FAIL basic_latency: got %0d expected 10", e); end
        n_checks++;
        if (q !== 4'd4 || r !== 4'd1 || z !== 1'b0) begin
            n_fail++; $display("FAIL basic_result: got %0d r%0d dbz=%0b expected 4 r1 dbz=0", q, r, z);
        end
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_after_done: got done=%0b busy=%0b expected 0 0", done, busy);
        end
        n_checks++;
        if (quotient !== 4'd4 || remainder !== 4'd1) begin
            n_fail++; $display("FAIL basic_hold: got %0d r%0d expected 4 r1", quotient, remainder);
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] q, r; logic z; int e;
        run_op(4'd9, 4'd0, q, r, z, e);
        n_checks++;
        if (e !== ZERO_EDGES) begin
            n_fail++; $display("FAIL dbz_latency: got %0d expected %0d", e, ZERO_EDGES);
        end
        n_checks++;
        if (q !== 4'd15 || r !== 4'd9 || z !== ZERO_DBZ) begin
            n_fail++; $display("FAIL dbz_result: got %0d r%0d dbz=%0b expected 15 r9 dbz=%0b", q, r, z, ZERO_DBZ);
        end
        n_checks++;
        if (dbz !== ZERO_DBZ) begin
            n_fail++; $display("FAIL dbz_hold: got %0b expected %0b", dbz, ZERO_DBZ);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int e1 = -1, e2 = -1;
        logic [W-1:0] q1 = '0, r1 = '0, q2 = '0, r2 = '0;
        dividend = 4'd15; divisor = 4'd1; start = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk); #1;
            if (e == 2)  begin dividend = 4'd2; divisor = 4'd7; end
            if (e == 12) start = 1'b0;
            if (done === 1'b1) begin
                pulses++;
                if (pulses == 1) begin e1 = e; q1 = quotient; r1 = remainder; end
                if (pulses == 2) begin e2 = e; q2 = quotient; r2 = remainder; end
            end
        end
        n_checks++;
        if (pulses !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
        n_checks++;
        if (e1 !== 10 || q1 !== 4'd15 || r1 !== 4'd0) begin
            n_fail++; $display("FAIL b2b_first: got edge %0d %0d r%0d expected edge 10 15 r0", e1, q1, r1);
        end
        n_checks++;
        if (e2 !== 21 || q2 !== 4'd0 || r2 !== 4'd2) begin
            n_fail++; $display("FAIL b2b_second: got edge %0d %0d r%0d expected edge 21 0 r2", e2, q2, r2);
        end
    endtask

    task automatic test_input_change();
        int pulses = 0;
        int e1 = -1;
        logic [W-1:0] q1 = '0, r1 = '0;
        dividend = 4'd13; divisor = 4'd3; start = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (e == 3) begin dividend = 4'd7;  divisor = 4'd2; start = 1'b1; end
            if (e == 5) begin dividend = 4'd15; divisor = 4'd0; start = 1'b1; end
            if (done === 1'b1) begin
                pulses++;
                if (pulses == 1) begin e1 = e; q1 = quotient; r1 = remainder; end
            end
        end
        n_checks++;
        if (pulses !== 1 || e1 !== 10) begin
            n_fail++; $display("FAIL ignore_pulses: got %0d pulses first edge %0d expected 1 at 10", pulses, e1);
        end
        n_checks++;
        if (q1 !== 4'd4 || r1 !== 4'd1) begin
            n_fail++; $display("FAIL ignore_result: got %0d r%0d expected 4 r1", q1, r1);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] q, r; logic z; int e;
        dividend = 4'd13; divisor = 4'd3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({quotient, remainder, busy, done, dbz} !== '0) begin
            n_fail++; $display("FAIL midreset_outputs: got q=%0d r=%0d busy=%0b done=%0b dbz=%0b expected all 0",
                               quotient, remainder, busy, done, dbz);
        end
        n_checks++;
        if (dut.state !== IDLE) begin
            n_fail++; $display("FAIL midreset_state: got %0d expected %0d", dut.state, IDLE);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(4'd12, 4'd5, q, r, z, e);
        n_checks++;
        if (q !== 4'd2 || r !== 4'd2 || e !== 10) begin
            n_fail++; $display("FAIL midreset_rerun: got %0d r%0d edge %0d expected 2 r2 edge 10", q, r, e);
        end
    endtask

    task automatic test_exhaustive();
        logic [W-1:0] q, r; logic z; int e;
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_op(4'(a), 4'(b), q, r, z, e);
                n_checks++;
                if (int'(q) * b + int'(r) != a || int'(r) >= b || int'(q) != a / b || z !== 1'b0 || e != 10) begin
                    n_fail++;
                    $display("FAIL exhaustive %0d/%0d: got %0d r%0d dbz=%0b edge %0d expected %0d r%0d dbz=0 edge 10",
                             a, b, q, r, z, e, a / b, a % b);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_back_to_back();
        test_input_change();
        test_reset_mid();
        test_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
